prbg_gen2: RTL and testbench

Parametrised dual-LFSR pseudo-random bit generator, successor to the fixed 4-bit pattern-generator pair.
- Two W-bit Galois LFSRs (A, B) with run-time seeds and tap masks.
- Selectable compare mode produces one random bit per step.
- Bits are packed MSB-first into OUT_W-bit words, delivered over a valid/ready handshake with back-pressure stall.
- Feeds the pattern-detector datapath and test-stimulus paths.

---
 rtl/prbg_gen2.sv | 143 ++++++++++++++
 tb/tb_prbg_gen2.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbg_gen2.sv
`default_nettype none
// ============================================================================
// Module   : prbg_gen2
// Brief    : Dual Galois-LFSR pseudo-random bit generator with MSB-first
//            word packing and a valid/ready word output with stall.
// Revision : 1.0 - initial release
// ============================================================================
module prbg_gen2 #(
    parameter int unsigned    W          = 8,
    parameter int unsigned    OUT_W      = 8,
    parameter logic [W-1:0]   DEF_TAPS_A = 8'hB8,
    parameter logic [W-1:0]   DEF_TAPS_B = 8'h8E
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [W-1:0]     seed_a,
    input  logic [W-1:0]     seed_b,
    input  logic [W-1:0]     taps_a,
    input  logic [W-1:0]     taps_b,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     threshold,
    input  logic             run,
    input  logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [OUT_W-1:0] word_out,
    output logic             word_valid,
    output logic             lockup,
    output logic             busy
);

    localparam int unsigned    CW       = $clog2(OUT_W);
    localparam logic [CW-1:0]  c_last   = CW'(OUT_W - 1);
    localparam logic [CW-1:0]  c_cnt_1  = CW'(1);
    localparam logic [W-1:0]   c_one    = W'(1);

    localparam logic [1:0]     c_idle   = 2'd0;
    localparam logic [1:0]     c_run    = 2'd1;
    localparam logic [1:0]     c_hold   = 2'd2;

    logic [W-1:0]     r_sa, r_sb, r_ta, r_tb;
    logic [CW-1:0]    r_cnt;
    logic [OUT_W-2:0] r_shreg;
    logic [1:0]       r_state;

    logic             w_bit;
    logic [W:0]       w_step_a, w_step_b;
    logic [OUT_W-1:0] w_shnext;
    logic             w_last, w_stall, w_hs;

    // Returns {zero_replaced, next_state}; an all-zero state would lock the LFSR.
    function automatic logic [W:0] lfsr_step(input logic [W-1:0] s, input logic [W-1:0] t);
        logic [W-1:0] n;
        n = (s >> 1) ^ (s[0] ? t : '0);
        return (n == '0) ? {1'b1, c_one} : {1'b0, n};
    endfunction

    always_comb begin
        w_bit = (r_sa > r_sb);
        case (mode)
            2'b01:   w_bit = (r_sa > threshold);
            2'b10:   w_bit = r_sa[0] ^ r_sb[0];
            default: w_bit = (r_sa > r_sb);
        endcase
    end

    assign w_step_a = lfsr_step(r_sa, r_ta);
    assign w_step_b = lfsr_step(r_sb, r_tb);
    assign w_shnext = {r_shreg, w_bit};
    assign w_last   = (r_cnt == c_last);
    assign w_stall  = w_last && word_valid && !word_ready;
    assign w_hs     = word_valid && word_ready;
    assign busy     = (r_state != c_idle);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sa       <= c_one;
            r_sb       <= c_one;
            r_ta       <= DEF_TAPS_A;
            r_tb       <= DEF_TAPS_B;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_state    <= c_idle;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            lockup     <= 1'b0;
        end else if (load) begin
            r_sa       <= (seed_a == '0) ? c_one : seed_a;
            r_sb       <= (seed_b == '0) ? c_one : seed_b;
            r_ta       <= (taps_a == '0) ? DEF_TAPS_A : taps_a;
            r_tb       <= (taps_b == '0) ? DEF_TAPS_B : taps_b;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_state    <= c_idle;
            bit_valid  <= 1'b0;
            word_valid <= 1'b0;
            lockup     <= (seed_a == '0) || (seed_b == '0);
        end else begin
            // A pending word retires on handshake; a completing step below overrides.
            if (w_hs) word_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    bit_valid <= 1'b0;
                    if (run) r_state <= c_run;
                end
                c_run: begin
                    if (!run) begin
                        bit_valid <= 1'b0;
                        r_state   <= c_idle;
                    end else if (w_stall) begin
                        bit_valid <= 1'b0;
                        r_state   <= c_hold;
                    end else begin
                        bit_out   <= w_bit;
                        bit_valid <= 1'b1;
                        r_sa      <= w_step_a[W-1:0];
                        r_sb      <= w_step_b[W-1:0];
                        lockup    <= lockup | w_step_a[W] | w_step_b[W];
                        r_shreg   <= w_shnext[OUT_W-2:0];
                        if (w_last) begin
                            word_out   <= w_shnext;
                            word_valid <= 1'b1;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_1;
                        end
                    end
                end
                c_hold: begin
                    bit_valid <= 1'b0;
                    if (!run)            r_state <= c_idle;
                    else if (word_ready) r_state <= c_run;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbg_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbg_gen2
// Brief    : Self-checking bench for prbg_gen2 (vector table + bit/word scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbg_gen2;

    localparam int W     = 8;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             load = 1'b0;
    logic [W-1:0]     seed_a = '0, seed_b = '0, taps_a = '0, taps_b = '0, threshold = '0;
    logic [1:0]       mode = 2'b00;
    logic             run = 1'b0;
    logic             word_ready = 1'b0;
    logic             bit_out, bit_valid, word_valid, lockup, busy;
    logic [OUT_W-1:0] word_out;

    always #5 clk = ~clk;

    prbg_gen2 #(.W(W), .OUT_W(OUT_W), .DEF_TAPS_A(8'hB8), .DEF_TAPS_B(8'h8E)) dut (
        .clk(clk), .res(res), .load(load), .seed_a(seed_a), .seed_b(seed_b),
        .taps_a(taps_a), .taps_b(taps_b), .mode(mode), .threshold(threshold),
        .run(run), .word_ready(word_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .word_out(word_out), .word_valid(word_valid), .lockup(lockup), .busy(busy)
    );

    int         checks = 0;
    int         errors = 0;
    bit         exp_bits[$];
    logic [7:0] exp_words[$];
    logic [7:0] words_copy[$];
    bit         mon_en = 1'b0;
    logic       pv, phs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid bit and every freshly presented word is popped and compared.
    always @(posedge clk) begin
        pv  = word_valid;
        phs = word_valid && word_ready;
        #1;
        if (mon_en && !res) begin
            if (bit_valid) begin
                if (exp_bits.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bit: got %0b expected none", bit_out);
                end else chk("bit_out", {31'b0, bit_out}, {31'b0, exp_bits.pop_front()});
            end
            if (word_valid && (!pv || phs)) begin
                if (exp_words.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %0h expected none", word_out);
                end else chk("word_out", {24'b0, word_out}, {24'b0, exp_words.pop_front()});
            end
        end
    end

    function automatic logic [8:0] mstep(input logic [7:0] s, input logic [7:0] t);
        logic [7:0] n;
        n = {1'b0, s[7:1]} ^ (s[0] ? t : 8'h00);
        return (n == 8'h00) ? 9'h101 : {1'b0, n};
    endfunction

    task automatic push_stream(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] ta0,
                               input logic [7:0] tb0, input logic [1:0] md, input logic [7:0] th,
                               input int nbits);
        logic [7:0] a, b, ta, tb, w;
        logic [8:0] na, nb;
        bit         f;
        a  = (a0 == 8'h00) ? 8'h01 : a0;
        b  = (b0 == 8'h00) ? 8'h01 : b0;
        ta = (ta0 == 8'h00) ? 8'hB8 : ta0;
        tb = (tb0 == 8'h00) ? 8'h8E : tb0;
        w  = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            case (md)
                2'b01:   f = (a > th);
                2'b10:   f = a[0] ^ b[0];
                default: f = (a > b);
            endcase
            exp_bits.push_back(f);
            w = {w[6:0], f};
            if ((i % 8) == 7) exp_words.push_back(w);
            na = mstep(a, ta);
            nb = mstep(b, tb);
            a  = na[7:0];
            b  = nb[7:0];
        end
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ta,
                           input logic [7:0] tb, input logic [1:0] md, input logic [7:0] th);
        @(negedge clk);
        seed_a = a; seed_b = b; taps_a = ta; taps_b = tb; mode = md; threshold = th;
        run = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_bits_left(input int n, input string what);
        int k;
        k = 0;
        while (exp_bits.size() > n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_bits.size() > n) begin
            checks++; errors++;
            $display("FAIL timeout_%s: got %0d bits left expected %0d", what, exp_bits.size(), n);
        end
    endtask

    task automatic wait_words_left(input int n, input string what);
        int k;
        k = 0;
        while (exp_words.size() > n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_words.size() > n) begin
            checks++; errors++;
            $display("FAIL timeout_%s: got %0d words left expected %0d", what, exp_words.size(), n);
        end
    endtask

    typedef struct {
        logic [7:0] sa, sb, ta, tb;
        logic [1:0] md;
        logic [7:0] th;
        bit         bit0;
        bit         lock_ld;
        bit         lock_end;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{8'h01, 8'h01, 8'hB8, 8'h8E, 2'b01, 8'h40, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h80, 8'h7F, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h03, 8'h01, 8'h00, 8'h00, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 8'h05, 8'h00, 8'h00, 2'b11, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'h03, 8'h02, 8'h01, 8'h00, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1};

        // Reset state, then free-run from the reset seeds and default taps.
        repeat (3) @(negedge clk);
        chk("rst_bit_out", {31'b0, bit_out}, 0);
        chk("rst_bit_valid", {31'b0, bit_valid}, 0);
        chk("rst_word_out", {24'b0, word_out}, 0);
        chk("rst_word_valid", {31'b0, word_valid}, 0);
        chk("rst_lockup", {31'b0, lockup}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        res = 1'b0;
        mode = 2'b01; threshold = 8'h40; word_ready = 1'b1;
        mon_en = 1'b1;
        push_stream(8'h01, 8'h01, 8'h00, 8'h00, 2'b01, 8'h40, 8);
        run = 1'b1;
        wait_bits_left(0, "reset_run");
        chk("reset_word", {24'b0, word_out}, 32'h67);
        chk("reset_word_valid", {31'b0, word_valid}, 1);
        run = 1'b0;

        // Table-driven: first-bit latency, compare modes, seed/taps zero handling.
        for (int r = 0; r < 5; r++) begin
            do_load(tbl[r].sa, tbl[r].sb, tbl[r].ta, tbl[r].tb, tbl[r].md, tbl[r].th);
            chk($sformatf("row%0d_lock_load", r), {31'b0, lockup}, {31'b0, tbl[r].lock_ld});
            chk($sformatf("row%0d_busy_load", r), {31'b0, busy}, 0);
            push_stream(tbl[r].sa, tbl[r].sb, tbl[r].ta, tbl[r].tb, tbl[r].md, tbl[r].th, 16);
            run = 1'b1;
            @(negedge clk);
            chk($sformatf("row%0d_busy_run", r), {31'b0, busy}, 1);
            chk($sformatf("row%0d_no_bit_yet", r), {31'b0, bit_valid}, 0);
            @(negedge clk);
            chk($sformatf("row%0d_bit0_valid", r), {31'b0, bit_valid}, 1);
            chk($sformatf("row%0d_bit0", r), {31'b0, bit_out}, {31'b0, tbl[r].bit0});
            wait_bits_left(0, $sformatf("row%0d", r));
            run = 1'b0;
            chk($sformatf("row%0d_lock_end", r), {31'b0, lockup}, {31'b0, tbl[r].lock_end});
            chk($sformatf("row%0d_words_left", r), exp_words.size(), 0);
            @(negedge clk);
            chk($sformatf("row%0d_idle", r), {31'b0, busy}, 0);
        end

        // Simultaneous retire+complete, back-pressure into HOLD, resume, load in HOLD.
        do_load(8'h01, 8'h01, 8'hB8, 8'h8E, 2'b01, 8'h40);
        push_stream(8'h01, 8'h01, 8'hB8, 8'h8E, 2'b01, 8'h40, 32);
        words_copy = exp_words;
        word_ready = 1'b1;
        run = 1'b1;
        wait_words_left(3, "word1");
        chk("bp_word1", {24'b0, word_out}, 32'h67);
        word_ready = 1'b0;
        wait_bits_left(17, "pre_simul");
        chk("pre_simul_valid", {31'b0, word_valid}, 1);
        word_ready = 1'b1;
        @(negedge clk);
        chk("simul_valid", {31'b0, word_valid}, 1);
        chk("simul_word", {24'b0, word_out}, {24'b0, words_copy[1]});
        chk("simul_words_left", exp_words.size(), 2);
        word_ready = 1'b0;
        wait_bits_left(9, "pre_hold");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_bit_valid", {31'b0, bit_valid}, 0);
            chk("hold_busy", {31'b0, busy}, 1);
            chk("hold_word_valid", {31'b0, word_valid}, 1);
            chk("hold_word_stable", {24'b0, word_out}, {24'b0, words_copy[1]});
            chk("hold_frozen", exp_bits.size(), 9);
        end
        word_ready = 1'b1;
        @(negedge clk);
        chk("resume_retired", {31'b0, word_valid}, 0);
        chk("resume_no_bit", {31'b0, bit_valid}, 0);
        @(negedge clk);
        chk("resume_word_valid", {31'b0, word_valid}, 1);
        chk("resume_word", {24'b0, word_out}, {24'b0, words_copy[2]});
        word_ready = 1'b0;
        wait_bits_left(1, "pre_hold2");
        repeat (2) @(negedge clk);
        chk("hold2_bit_valid", {31'b0, bit_valid}, 0);
        chk("hold2_frozen", exp_bits.size(), 1);
        do_load(8'h01, 8'h01, 8'hB8, 8'h8E, 2'b01, 8'h40);
        chk("hold_load_valid", {31'b0, word_valid}, 0);
        chk("hold_load_busy", {31'b0, busy}, 0);
        chk("hold_load_bit_valid", {31'b0, bit_valid}, 0);
        exp_bits.delete();
        exp_words.delete();
        push_stream(8'h01, 8'h01, 8'hB8, 8'h8E, 2'b01, 8'h40, 8);
        word_ready = 1'b1;
        run = 1'b1;
        wait_bits_left(0, "after_hold_load");
        chk("after_load_word", {24'b0, word_out}, 32'h67);
        run = 1'b0;

        // Asynchronous reset in the middle of a word.
        do_load(8'h80, 8'h7F, 8'h00, 8'h00, 2'b00, 8'h00);
        push_stream(8'h80, 8'h7F, 8'h00, 8'h00, 2'b00, 8'h00, 8);
        run = 1'b1;
        wait_bits_left(5, "mid_word");
        mon_en = 1'b0;
        #2 res = 1'b1;
        #1;
        chk("async_bit_valid", {31'b0, bit_valid}, 0);
        chk("async_bit_out", {31'b0, bit_out}, 0);
        chk("async_busy", {31'b0, busy}, 0);
        chk("async_word_valid", {31'b0, word_valid}, 0);
        @(negedge clk);
        res = 1'b0; run = 1'b0; mode = 2'b01; threshold = 8'h40;
        exp_bits.delete();
        exp_words.delete();
        @(negedge clk);
        chk("post_rst_word_valid", {31'b0, word_valid}, 0);
        mon_en = 1'b1;
        push_stream(8'h01, 8'h01, 8'h00, 8'h00, 2'b01, 8'h40, 8);
        run = 1'b1;
        wait_bits_left(0, "post_rst");
        chk("post_rst_word", {24'b0, word_out}, 32'h67);
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
